// File: rtl/fourteen_to_one_serializer_fsm.sv
// fourteen_to_one_serializer_fsm
//
// FSM-driven parallel-to-serial transmitter for the 1-to-14 slave-select link.
// A word is captured when start is seen in IDLE. It is framed by ss low and
// shifted out MSB first, each bit held for BIT_CYCLES clocks. After the frame,
// done stays high until the client acknowledges it.
//
// Ports:
//   clock    - system clock, rising-edge active
//   resetn   - asynchronous active-low reset
//   start    - send request, sampled only in IDLE
//   data_in  - parallel word, captured on the accepting edge
//   Ack      - acknowledge of done, honoured only in DONE
//   ss       - active-low frame select to the receiver
//   data_out - serial data, MSB first
//   busy     - high in SHIFT and DONE
//   done     - high in DONE
//   y_Q      - current state (IDLE=00, SHIFT=01, DONE=10)
module fourteen_to_one_serializer_fsm #(
  parameter int unsigned DATA_WIDTH = 14,
  parameter int unsigned BIT_CYCLES = 1,
  parameter int unsigned DIV_W      = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  Ack,
  output logic                  ss,
  output logic                  data_out,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            y_Q
);

  localparam int unsigned BitW = $clog2(DATA_WIDTH);
  localparam logic [BitW-1:0]  BitLast = BitW'(DATA_WIDTH - 1);
  localparam logic [DIV_W-1:0] DivLast = DIV_W'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

  state_e                  state_q;
  // The MSB of the word goes straight to data_out at capture, so only the
  // remaining DATA_WIDTH-1 bits need to be stored.
  logic [DATA_WIDTH-2:0]   shift_q;
  logic [BitW-1:0]         bit_cnt_q;
  logic [DIV_W-1:0]        div_cnt_q;
  logic                    ss_q;
  logic                    data_out_q;
  logic                    busy_q;
  logic                    done_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      ss_q       <= 1'b1;
      data_out_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          ss_q       <= 1'b1;
          data_out_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
          if (start) begin
            shift_q    <= data_in[DATA_WIDTH-2:0];
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            ss_q       <= 1'b0;
            data_out_q <= data_in[DATA_WIDTH-1];
            busy_q     <= 1'b1;
            state_q    <= StShift;
          end
        end

        StShift: begin
          if (div_cnt_q == DivLast) begin
            div_cnt_q <= '0;
            if (bit_cnt_q == BitLast) begin
              ss_q       <= 1'b1;
              data_out_q <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= StDone;
            end else begin
              data_out_q <= shift_q[DATA_WIDTH-2];
              shift_q    <= {shift_q[DATA_WIDTH-3:0], 1'b0};
              bit_cnt_q  <= bit_cnt_q + BitW'(1);
            end
          end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
          end
        end

        StDone: begin
          // start is deliberately not looked at here; a new frame needs a
          // start seen in IDLE, which guarantees the 2-cycle ss-high gap.
          if (Ack) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end

        default: begin
          // Illegal encoding 11: fall back to a clean idle.
          state_q    <= StIdle;
          ss_q       <= 1'b1;
          data_out_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
          bit_cnt_q  <= '0;
          div_cnt_q  <= '0;
        end
      endcase
    end
  end

  assign ss       = ss_q;
  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign y_Q      = state_q;

endmodule

// File: doc/fourteen_to_one_serializer_fsm.md
Name: fourteen_to_one_serializer_fsm

Overview:
- FSM-controlled 14-bit parallel-to-serial transmitter; the sending end of the 1-to-14 slave-select serial link.
- Latches a 14-bit word on a start request and frames it by driving ss low.
- Shifts the word out MSB first, one bit per bit period, then releases ss.
- Holds a done flag until the client acknowledges it. Feeds the deserializer's ss/data_in pins directly.

Parameters:
- DATA_WIDTH, 14, word length in bits; the link requires 14.
- BIT_CYCLES, 1, clock cycles each bit is held on data_out (>=1); 1 matches the one-bit-per-clock deserializer.
- DIV_W, 8, width of the bit-period counter; must satisfy BIT_CYCLES <= 2^DIV_W.

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  request to send data_in; sampled only in IDLE.
- data_in  input  DATA_WIDTH  parallel word, captured on the accepting edge.
- Ack  input  1  client acknowledge of done; honoured only in DONE.
- ss  output  1  active-low frame select to the receiver.
- data_out  output  1  serial data to the receiver, MSB first.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  high in DONE (word fully sent).
- y_Q  output  2  current state, debug.

Behaviour:
- Reset (asynchronous, resetn=0): state IDLE, ss=1, data_out=0, busy=0, done=0, shift register=0, counters=0, y_Q=00. Reset mid-frame aborts at once: ss rises asynchronously and no partial completion is reported.
- All outputs are registered. The state encoding is IDLE=00, SHIFT=01, DONE=10; 11 is illegal and recovers to IDLE on the next edge.
- IDLE:
  - ss=1, data_out=0.
  - On an edge with start=1: shift_reg<=data_in, bit_cnt<=0, div_cnt<=0, state->SHIFT.
  - On that same edge: ss<=0, data_out<=data_in[DATA_WIDTH-1], busy<=1.
  - Latency from start to ss low is 1 clock.
- SHIFT:
  - ss=0. Each bit is held exactly BIT_CYCLES cycles, counted by div_cnt from 0 to BIT_CYCLES-1.
  - At the end of a bit period with bit_cnt<DATA_WIDTH-1: shift left, data_out<=next bit, bit_cnt++, div_cnt<=0.
  - At the end of the last bit period (bit_cnt=DATA_WIDTH-1): ss<=1, data_out<=0, done<=1, state->DONE.
  - ss is low for exactly DATA_WIDTH*BIT_CYCLES consecutive cycles.
  - start is ignored, and data_in changes have no effect after capture.
- DONE:
  - ss=1, busy=1, done=1.
  - Ack=1 -> IDLE on the next edge (done<=0, busy<=0).
  - Ack held high is not required; a single-cycle pulse suffices.
- Ack outside DONE is ignored.
- start and Ack high together in DONE: only the Ack is taken, and the FSM goes to IDLE. start must be high on a later edge while in IDLE to begin a new frame.
- start held continuously high: back-to-back frames separated by at least 2 cycles of ss=1 (DONE exit plus IDLE accept), provided Ack is given.
- Minimum ss-high gap between frames is 2 cycles, enough for the receiver FSM to see the rising and falling ss edges.
- Bit-period counter wrap: div_cnt never exceeds BIT_CYCLES-1. With BIT_CYCLES=1, a bit changes every clock.

Test Plan:
- Reset release, then start=1 for 1 cycle with data_in=14'h2A5C, BIT_CYCLES=1 -> ss low on the next edge for exactly 14 cycles. data_out sequence is 1,0,1,0,1,0,0,1,0,1,1,1,0,0. Then ss=1 and done=1.
- In DONE, hold Ack=0 for 20 cycles, then pulse Ack for 1 cycle -> done stays 1, ss stays 1 throughout; on the Ack edge done=0, busy=0, y_Q=00.
- BIT_CYCLES=3 with data_in=14'h3FFF, then 14'h0001 -> ss low for 42 cycles. The second word gives data_out=0 for 39 cycles and 1 for the final 3.
- Assert resetn=0 asynchronously at bit 6 of a frame -> ss=1, data_out=0, busy=0 immediately, with no done pulse. A new start after release sends the full new word.
- start and Ack both high in DONE, and start pulses during SHIFT -> no frame restart in SHIFT; FSM goes DONE->IDLE and the next frame begins only on a later start.
- Loopback into the 1-to-14 deserializer, sending 14'h1234 and 14'h0F0F -> receiver data_out matches each word and receiver ready asserts once per frame.
